// File: rtl/simframe_pkg.sv
// rtl/simframe_pkg.sv - shared frame geometry, error-bit indices and output register states
// Used by the simulated-frame checker and meant to be shared with the generator
// so both ends agree on the frame shape.
package simframe_pkg;

  localparam int CYCLES_PER_ROW_DEFAULT = 4;
  localparam int ROWS_PER_FRAME_DEFAULT = 3;

  // Bit positions inside the per-beat error vector and the sticky flag register.
  localparam int ERR_REPLICATE = 0;
  localparam int ERR_PATTERN   = 1;
  localparam int ERR_TLAST     = 2;
  localparam int ERR_BITS      = 3;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/simframe_lane_cmp.sv
// rtl/simframe_lane_cmp.sv - combinational lane replication check and lane-0 extraction
// Ports:
//   data    : LANES x PATTERN_WIDTH input beat
//   lane0   : lowest lane, the reference copy of the pattern
//   rep_bad : 1 when any lane differs from lane 0
module simframe_lane_cmp
  import simframe_pkg::*;
#(
  parameter int PATTERN_WIDTH = 32,
  parameter int LANES         = 16
) (
  input  logic [PATTERN_WIDTH*LANES-1:0] data,
  output logic [PATTERN_WIDTH-1:0]       lane0,
  output logic                           rep_bad
);

  always_comb begin
    lane0   = data[PATTERN_WIDTH-1:0];
    rep_bad = 1'b0;
    for (int i = 1; i < LANES; i++) begin
      if (data[i*PATTERN_WIDTH +: PATTERN_WIDTH] != data[PATTERN_WIDTH-1:0]) begin
        rep_bad = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simframe_check.sv
// rtl/simframe_check.sv - receiving end of the simulated-frame stream
// Checks lane replication, pattern constancy across a frame and TLAST placement,
// and emits one recovered pattern per frame tagged with a per-frame error bit.
// Ports:
//   clk, resetn                      : clock, asynchronous active-low reset
//   AXIS_IN_*                        : replicated frame data, TLAST closes each row
//   AXIS_OUT_*                       : recovered pattern, TUSER = frame had an error
//   clear_errors                     : pulse clearing sticky flags and counters
//   err_replicate/err_pattern/err_tlast : sticky error flags
//   frame_count, bad_frame_count     : wrapping frame counters
module simframe_check
  import simframe_pkg::*;
#(
  parameter int PATTERN_WIDTH  = 32,
  parameter int INPUT_WIDTH    = 512,
  parameter int CYCLES_PER_ROW = CYCLES_PER_ROW_DEFAULT,
  parameter int ROWS_PER_FRAME = ROWS_PER_FRAME_DEFAULT
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [INPUT_WIDTH-1:0]   AXIS_IN_TDATA,
  input  logic                     AXIS_IN_TVALID,
  input  logic                     AXIS_IN_TLAST,
  output logic                     AXIS_IN_TREADY,
  output logic [PATTERN_WIDTH-1:0] AXIS_OUT_TDATA,
  output logic                     AXIS_OUT_TUSER,
  output logic                     AXIS_OUT_TVALID,
  input  logic                     AXIS_OUT_TREADY,
  input  logic                     clear_errors,
  output logic                     err_replicate,
  output logic                     err_pattern,
  output logic                     err_tlast,
  output logic [31:0]              frame_count,
  output logic [31:0]              bad_frame_count
);

  localparam int LANES = INPUT_WIDTH / PATTERN_WIDTH;
  localparam int BW    = (CYCLES_PER_ROW > 1) ? $clog2(CYCLES_PER_ROW) : 1;
  localparam int RW    = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;

  out_state_e              state_q, state_d;
  logic [BW-1:0]           beat_cnt;
  logic [RW-1:0]           row_cnt;
  logic [PATTERN_WIDTH-1:0] ref_q, ref_next, lane0;
  logic                    frame_err;
  logic [ERR_BITS-1:0]     err_flags;
  logic [ERR_BITS-1:0]     beat_err;
  logic                    rep_bad, first_beat, last_beat, accept, frame_end, drain;

  simframe_lane_cmp #(
    .PATTERN_WIDTH(PATTERN_WIDTH),
    .LANES        (LANES)
  ) u_lane_cmp (
    .data   (AXIS_IN_TDATA),
    .lane0  (lane0),
    .rep_bad(rep_bad)
  );

  // Ready depends on the downstream ready so a frame end may coincide with a drain.
  assign AXIS_IN_TREADY  = resetn & (!AXIS_OUT_TVALID | AXIS_OUT_TREADY);
  assign AXIS_OUT_TVALID = (state_q == OUT_FULL);
  assign err_replicate   = err_flags[ERR_REPLICATE];
  assign err_pattern     = err_flags[ERR_PATTERN];
  assign err_tlast       = err_flags[ERR_TLAST];

  always_comb begin
    accept     = AXIS_IN_TVALID & AXIS_IN_TREADY;
    drain      = AXIS_OUT_TVALID & AXIS_OUT_TREADY;
    first_beat = (beat_cnt == '0) && (row_cnt == '0);
    last_beat  = (beat_cnt == BW'(CYCLES_PER_ROW - 1));
    // A single-row frame may end on its first beat, so the output must see the fresh reference.
    ref_next   = first_beat ? lane0 : ref_q;
    beat_err                = '0;
    beat_err[ERR_REPLICATE] = rep_bad;
    beat_err[ERR_PATTERN]   = !first_beat && (lane0 != ref_q);
    beat_err[ERR_TLAST]     = AXIS_IN_TLAST ^ last_beat;
    frame_end  = accept & AXIS_IN_TLAST & (row_cnt == RW'(ROWS_PER_FRAME - 1));

    state_d = state_q;
    if (frame_end) begin
      state_d = OUT_FULL;
    end else if (drain) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt       <= '0;
      row_cnt        <= '0;
      ref_q          <= '0;
      frame_err      <= 1'b0;
      AXIS_OUT_TDATA <= '0;
      AXIS_OUT_TUSER <= 1'b0;
    end else if (accept) begin
      ref_q <= ref_next;
      if (AXIS_IN_TLAST) begin
        beat_cnt <= '0;
        if (frame_end) begin
          row_cnt        <= '0;
          frame_err      <= 1'b0;
          AXIS_OUT_TDATA <= ref_next;
          AXIS_OUT_TUSER <= frame_err | (|beat_err);
        end else begin
          row_cnt   <= row_cnt + 1'b1;
          frame_err <= frame_err | (|beat_err);
        end
      end else begin
        // Saturate so a missing TLAST keeps flagging on every extra beat.
        if (!last_beat) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        frame_err <= frame_err | (|beat_err);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_flags       <= '0;
      frame_count     <= '0;
      bad_frame_count <= '0;
    end else if (clear_errors) begin
      err_flags       <= '0;
      frame_count     <= '0;
      bad_frame_count <= '0;
    end else begin
      if (accept) begin
        err_flags <= err_flags | beat_err;
      end
      if (frame_end) begin
        frame_count <= frame_count + 32'd1;
        if (frame_err | (|beat_err)) begin
          bad_frame_count <= bad_frame_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_simframe_check.sv
// tb/tb_simframe_check.sv - scoreboard bench for simframe_check
module tb_simframe_check;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [511:0] in_tdata = '0;
  logic         in_tvalid = 1'b0;
  logic         in_tlast = 1'b0;
  logic         in_tready;
  logic [31:0]  out_tdata;
  logic         out_tuser;
  logic         out_tvalid;
  logic         out_tready = 1'b1;
  logic         clear_errors = 1'b0;
  logic         err_replicate, err_pattern, err_tlast;
  logic [31:0]  frame_count, bad_frame_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        u;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  simframe_check dut (
    .clk            (clk),
    .resetn         (resetn),
    .AXIS_IN_TDATA  (in_tdata),
    .AXIS_IN_TVALID (in_tvalid),
    .AXIS_IN_TLAST  (in_tlast),
    .AXIS_IN_TREADY (in_tready),
    .AXIS_OUT_TDATA (out_tdata),
    .AXIS_OUT_TUSER (out_tuser),
    .AXIS_OUT_TVALID(out_tvalid),
    .AXIS_OUT_TREADY(out_tready),
    .clear_errors   (clear_errors),
    .err_replicate  (err_replicate),
    .err_pattern    (err_pattern),
    .err_tlast      (err_tlast),
    .frame_count    (frame_count),
    .bad_frame_count(bad_frame_count)
  );

  // Monitor: a transfer happens on the next rising edge when valid & ready at the falling edge.
  always @(negedge clk) begin
    if (resetn && out_tvalid && out_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got tdata=%h tuser=%b", out_tdata, out_tuser);
      end else begin
        e = exp_q.pop_front();
        if (out_tdata !== e.d || out_tuser !== e.u) begin
          errors++;
          $display("FAIL output got tdata=%h tuser=%b want tdata=%h tuser=%b",
                   out_tdata, out_tuser, e.d, e.u);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic expect_frame(input logic [31:0] d, input logic u);
    exp_t x;
    x.d = d;
    x.u = u;
    exp_q.push_back(x);
  endtask

  // Present one beat; it is accepted on the rising edge after a falling edge that sees ready.
  task automatic send_beat(input logic [511:0] d, input logic l);
    int n = 0;
    logic ok = 1'b0;
    in_tdata  = d;
    in_tlast  = l;
    in_tvalid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_tready;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got ready=0 want ready=1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] p, input logic [31:0] p_mid,
                            input int glitch_beat, input int row0_len);
    int b = 0;
    logic [511:0] d;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < ((r == 0) ? row0_len : 4); c++) begin
        b++;
        d = {16{(r == 1) ? p_mid : p}};
        if (b == glitch_beat) d[7*32 +: 32] = 32'hDEADBEEF;
        send_beat(d, c == (((r == 0) ? row0_len : 4) - 1));
      end
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_tvalid) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
    end
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #2 clear_errors = 1'b1;
    @(posedge clk);
    #2 clear_errors = 1'b0;
  endtask

  initial begin
    #2;
    chk("reset_in_tready", in_tready, 0);
    chk("reset_out_tvalid", out_tvalid, 0);
    chk("reset_frame_count", frame_count, 0);
    chk("reset_flags", {err_replicate, err_pattern, err_tlast}, 0);
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    #1 chk("ready_after_reset", in_tready, 1);

    // Clean frame.
    expect_frame(32'hA5A5_0001, 1'b0);
    send_frame(32'hA5A5_0001, 32'hA5A5_0001, 0, 4);
    wait_drain();
    chk("clean_frame_count", frame_count, 1);
    chk("clean_bad_count", bad_frame_count, 0);
    chk("clean_flags", {err_replicate, err_pattern, err_tlast}, 0);

    // Lane 7 of beat 6 corrupted, then a clean frame.
    expect_frame(32'hA5A5_0001, 1'b1);
    send_frame(32'hA5A5_0001, 32'hA5A5_0001, 6, 4);
    expect_frame(32'hA5A5_0001, 1'b0);
    send_frame(32'hA5A5_0001, 32'hA5A5_0001, 0, 4);
    wait_drain();
    chk("rep_flags", {err_replicate, err_pattern, err_tlast}, 3'b100);
    chk("rep_bad_count", bad_frame_count, 1);
    chk("rep_frame_count", frame_count, 3);

    pulse_clear();
    #1 chk("clear_flags", {err_replicate, err_pattern, err_tlast}, 0);
    chk("clear_frame_count", frame_count, 0);
    chk("clear_bad_count", bad_frame_count, 0);

    // Middle row carries a different (but replicated) pattern.
    expect_frame(32'h0000_0001, 1'b1);
    send_frame(32'h0000_0001, 32'h0000_0002, 0, 4);
    wait_drain();
    chk("pat_flags", {err_replicate, err_pattern, err_tlast}, 3'b010);
    chk("pat_bad_count", bad_frame_count, 1);
    pulse_clear();

    // Early TLAST on beat 3 of the first row; frame closes on the third TLAST.
    expect_frame(32'h1234_5678, 1'b1);
    send_frame(32'h1234_5678, 32'h1234_5678, 0, 3);
    wait_drain();
    chk("tlast_flags", {err_replicate, err_pattern, err_tlast}, 3'b001);
    chk("tlast_frame_count", frame_count, 1);
    chk("tlast_bad_count", bad_frame_count, 1);
    pulse_clear();

    // Output back-pressure across two back-to-back frames.
    @(posedge clk);
    #2 out_tready = 1'b0;
    expect_frame(32'h0BAD_F00D, 1'b0);
    expect_frame(32'h0C0F_FEE0, 1'b0);
    fork
      begin
        send_frame(32'h0BAD_F00D, 32'h0BAD_F00D, 0, 4);
        send_frame(32'h0C0F_FEE0, 32'h0C0F_FEE0, 0, 4);
      end
      begin
        repeat (40) @(posedge clk);
        #2;
        chk("hold_out_tvalid", out_tvalid, 1);
        chk("hold_out_tdata", out_tdata, 32'h0BAD_F00D);
        chk("hold_in_tready", in_tready, 0);
        chk("hold_frame_count", frame_count, 1);
        out_tready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_frame_count", frame_count, 2);

    // Reset in the middle of a frame discards it.
    for (int c = 0; c < 5; c++) send_beat({16{32'h7777_7777}}, c == 3);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    @(posedge clk);
    #2 resetn = 1'b0;
    @(posedge clk);
    #2 resetn = 1'b1;
    chk("midreset_frame_count", frame_count, 0);
    chk("midreset_out_tvalid", out_tvalid, 0);
    expect_frame(32'h5555_AAAA, 1'b0);
    send_frame(32'h5555_AAAA, 32'h5555_AAAA, 0, 4);
    wait_drain();
    chk("postreset_frame_count", frame_count, 1);
    chk("postreset_flags", {err_replicate, err_pattern, err_tlast}, 0);

    // Bad frame then clear zeroes both counters.
    expect_frame(32'h5555_AAAA, 1'b1);
    send_frame(32'h5555_AAAA, 32'h5555_AAAA, 2, 4);
    wait_drain();
    chk("pre_clear_bad_count", bad_frame_count, 1);
    pulse_clear();
    #1 chk("final_frame_count", frame_count, 0);
    chk("final_bad_count", bad_frame_count, 0);
    chk("final_flags", {err_replicate, err_pattern, err_tlast}, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
